// File: rtl/multicycle_control_fsm_if.sv
// Control/status bundle between the multi-cycle sequencer (master) and the
// datapath plus shared memory port (slave).
interface multicycle_control_fsm_if #(
  parameter int RETIRE_W = 32
);
  logic [31:0]         instruction;
  logic                zero;
  logic                mem_ready;

  logic                mem_req;
  logic                mem_we;
  logic                ir_write;
  logic                pc_write;
  logic [1:0]          pc_src;
  logic                alu_src;
  logic [1:0]          alu_op;
  logic                reg_write;
  logic [1:0]          wb_sel;
  logic [2:0]          state;
  logic                instr_retired;
  logic [RETIRE_W-1:0] retire_count;
  logic                illegal_insn;

  modport master (
    input  instruction, zero, mem_ready,
    output mem_req, mem_we, ir_write, pc_write, pc_src, alu_src, alu_op,
           reg_write, wb_sel, state, instr_retired, retire_count, illegal_insn
  );

  modport slave (
    output instruction, zero, mem_ready,
    input  mem_req, mem_we, ir_write, pc_write, pc_src, alu_src, alu_op,
           reg_write, wb_sel, state, instr_retired, retire_count, illegal_insn
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// FETCH/DECODE/EXECUTE/MEM/WB sequencer for the RV32I subset core.
// Define ILLEGAL_TRAP_EN to trap on illegal opcodes; otherwise they retire as NOPs.
module multicycle_control_fsm #(
  parameter int RETIRE_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_t;

  localparam logic [6:0] OP_R    = 7'h33;
  localparam logic [6:0] OP_ADDI = 7'h13;
  localparam logic [6:0] OP_LW   = 7'h03;
  localparam logic [6:0] OP_SW   = 7'h23;
  localparam logic [6:0] OP_BEQ  = 7'h63;
  localparam logic [6:0] OP_JAL  = 7'h6F;

  state_t              state_q, state_d;
  logic [RETIRE_W-1:0] retire_count_q, retire_count_d;

  logic [6:0] opcode;
  logic       is_r, is_addi, is_lw, is_sw, is_beq, is_jal, is_legal;

  logic       mem_req_c, mem_we_c, ir_write_c, pc_write_c;
  logic [1:0] pc_src_c, alu_op_c, wb_sel_c;
  logic       alu_src_c, reg_write_c, retire_c;

  assign opcode   = bus.instruction[6:0];
  assign is_r     = (opcode == OP_R);
  assign is_addi  = (opcode == OP_ADDI);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_jal   = (opcode == OP_JAL);
  assign is_legal = is_r | is_addi | is_lw | is_sw | is_beq | is_jal;

  // Strobes are Mealy: they depend on the registered state, the opcode and,
  // where a transition is conditional, on mem_ready/zero in the same cycle.
  always_comb begin
    state_d     = state_q;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    pc_src_c    = 2'b00;
    alu_src_c   = 1'b0;
    alu_op_c    = 2'b00;
    reg_write_c = 1'b0;
    wb_sel_c    = 2'b00;
    retire_c    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (bus.mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          pc_src_c   = 2'b00;
          state_d    = S_DECODE;
        end
      end

      S_DECODE: begin
        if (is_legal) begin
          state_d = S_EXECUTE;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          retire_c = 1'b1;
          state_d  = S_FETCH;
`endif
        end
      end

      S_EXECUTE: begin
        alu_src_c = is_addi | is_lw | is_sw;
        if (is_lw || is_sw) begin
          alu_op_c = 2'b00;
        end else if (is_beq) begin
          alu_op_c = 2'b01;
        end else if (is_r || is_addi) begin
          alu_op_c = 2'b10;
        end

        if (is_beq) begin
          pc_write_c = bus.zero;
          pc_src_c   = 2'b01;
          retire_c   = 1'b1;
          state_d    = S_FETCH;
        end else if (is_jal) begin
          pc_write_c  = 1'b1;
          pc_src_c    = 2'b10;
          reg_write_c = 1'b1;
          wb_sel_c    = 2'b10;
          retire_c    = 1'b1;
          state_d     = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        mem_req_c = 1'b1;
        mem_we_c  = is_sw;
        if (bus.mem_ready) begin
          if (is_sw) begin
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        reg_write_c = 1'b1;
        wb_sel_c    = is_lw ? 2'b01 : 2'b00;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end

      S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        state_d = S_TRAP;
`else
        state_d = S_FETCH;
`endif
      end

      default: state_d = S_FETCH;
    endcase

    retire_count_d = retire_count_q + RETIRE_W'(retire_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_FETCH;
      retire_count_q <= '0;
    end else begin
      state_q        <= state_d;
      retire_count_q <= retire_count_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  always_comb begin
    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign bus.illegal_insn = illegal_q & ~rst;
`else
  assign bus.illegal_insn = 1'b0;
`endif

  // Everything reads 0 while reset is held, even before the first edge clears state.
  assign bus.mem_req       = mem_req_c   & ~rst;
  assign bus.mem_we        = mem_we_c    & ~rst;
  assign bus.ir_write      = ir_write_c  & ~rst;
  assign bus.pc_write      = pc_write_c  & ~rst;
  assign bus.pc_src        = rst ? 2'b00 : pc_src_c;
  assign bus.alu_src       = alu_src_c   & ~rst;
  assign bus.alu_op        = rst ? 2'b00 : alu_op_c;
  assign bus.reg_write     = reg_write_c & ~rst;
  assign bus.wb_sel        = rst ? 2'b00 : wb_sel_c;
  assign bus.state         = rst ? 3'd0 : state_q;
  assign bus.instr_retired = retire_c    & ~rst;
  assign bus.retire_count  = rst ? '0 : retire_count_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: directed cases from the
// instruction rules, then a randomized instruction/wait-state stream.
module tb_multicycle_control_fsm;
  localparam int RW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_control_fsm_if #(.RETIRE_W(RW)) bus ();
  multicycle_control_fsm #(.RETIRE_W(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int checks   = 0;
  int failures = 0;
  int exp_count = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one instruction from FETCH to its retire pulse. The memory model makes
  // the fetch wait fw cycles and the data access wait mw cycles; expectations come
  // from the per-class cost: FETCH/MEM take 1+waits, every other phase 1 cycle.
  task automatic run_insn(input string name, input logic [31:0] insn, input int fw,
                          input int mw, input logic z, output logic [63:0] trace);
    int lat = 0, mreq = 0, mwe = 0, irw = 0, pcw = 0, regw = 0;
    int phase = 0, waited = 0, need;
    logic [1:0] last_src = 2'b00, wbs = 2'b00, aop = 2'b00;
    logic asrc = 1'b0;
    logic done = 1'b0;
    int e_lat, e_mreq, e_mwe, e_pcw, e_regw;
    logic [1:0] e_src, e_wb, e_aop;
    logic e_asrc;

    trace = '0;
    bus.instruction = insn;
    bus.zero = z;
    while (!done && lat < 40) begin
      if (bus.mem_req) begin
        need = (phase == 0) ? fw : mw;
        if (waited >= need) begin
          bus.mem_ready = 1'b1;
          waited = 0;
          phase++;
        end else begin
          bus.mem_ready = 1'b0;
          waited++;
        end
      end else begin
        bus.mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      lat++;
      trace = {trace[59:0], 1'b0, bus.state};
      if (bus.mem_req) mreq++;
      if (bus.mem_we) mwe++;
      if (bus.ir_write) irw++;
      if (bus.pc_write) begin pcw++; last_src = bus.pc_src; end
      if (bus.reg_write) begin regw++; wbs = bus.wb_sel; end
      if (bus.state == 3'd2) begin asrc = bus.alu_src; aop = bus.alu_op; end
      done = bus.instr_retired;
      @(posedge clk); #1;
    end

    e_mwe = 0; e_regw = 0; e_wb = 2'b00; e_src = 2'b00; e_pcw = 1;
    e_asrc = 1'b0; e_aop = 2'b00; e_mreq = fw + 1;
    case (insn[6:0])
      7'h33: begin e_lat = 4 + fw; e_regw = 1; e_aop = 2'b10; end
      7'h13: begin e_lat = 4 + fw; e_regw = 1; e_aop = 2'b10; e_asrc = 1'b1; end
      7'h03: begin e_lat = 5 + fw + mw; e_mreq = fw + mw + 2; e_regw = 1; e_wb = 2'b01; e_asrc = 1'b1; end
      7'h23: begin e_lat = 4 + fw + mw; e_mreq = fw + mw + 2; e_mwe = mw + 1; e_asrc = 1'b1; end
      7'h63: begin e_lat = 3 + fw; e_aop = 2'b01; if (z) begin e_pcw = 2; e_src = 2'b01; end end
      7'h6F: begin e_lat = 3 + fw; e_pcw = 2; e_src = 2'b10; e_regw = 1; e_wb = 2'b10; end
      default: e_lat = 2 + fw;
    endcase

    check({name, " retired"}, 32'(done), 32'd1);
    check({name, " latency"}, lat, e_lat);
    check({name, " mem_req_cycles"}, mreq, e_mreq);
    check({name, " mem_we_cycles"}, mwe, e_mwe);
    check({name, " ir_write_cycles"}, irw, 1);
    check({name, " pc_write_cycles"}, pcw, e_pcw);
    check({name, " last_pc_src"}, 32'(last_src), 32'(e_src));
    check({name, " reg_write_cycles"}, regw, e_regw);
    check({name, " wb_sel"}, 32'(wbs), 32'(e_wb));
    check({name, " alu_src"}, 32'(asrc), 32'(e_asrc));
    check({name, " alu_op"}, 32'(aop), 32'(e_aop));
    exp_count = (exp_count + 1) % (1 << RW);
    check({name, " retire_count"}, 32'(bus.retire_count), exp_count);
    check({name, " back_in_fetch"}, 32'(bus.state), 0);
    $display("insn %s 0x%08h fw=%0d mw=%0d zero=%0b lat=%0d count=%0d",
             name, insn, fw, mw, z, lat, bus.retire_count);
  endtask

  logic [63:0] tr;
  logic [31:0] rnd;
  logic [6:0]  ops [7];
  logic [6:0]  op;
  int          n_ops;
  int          n;

  initial begin
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h7F};
    rst = 1'b1;
    bus.instruction = 32'h0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;

    @(posedge clk); #1;
    check("rst mem_req", 32'(bus.mem_req), 0);
    check("rst ir_write", 32'(bus.ir_write), 0);
    check("rst state", 32'(bus.state), 0);
    check("rst retire_count", 32'(bus.retire_count), 0);
    check("rst illegal", 32'(bus.illegal_insn), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst state", 32'(bus.state), 0);
    check("post_rst mem_req", 32'(bus.mem_req), 1);
    check("post_rst retire_count", 32'(bus.retire_count), 0);
    exp_count = 0;

    run_insn("addi", 32'h00500093, 0, 0, 1'b0, tr);
    check("addi trace", tr[31:0], 32'h0000_0124);
    run_insn("lw_wait3", 32'h0000A103, 0, 3, 1'b0, tr);
    check("lw trace", tr[31:0], 32'h0123_3334);
    run_insn("beq_taken", 32'h00208463, 0, 0, 1'b1, tr);
    run_insn("beq_not", 32'h00208463, 0, 0, 1'b0, tr);
    run_insn("jal", 32'h008000EF, 0, 0, 1'b0, tr);
    run_insn("sw", 32'h0020A223, 0, 0, 1'b0, tr);
    check("sw trace", tr[31:0], 32'h0000_0123);
    run_insn("add", 32'h002081B3, 1, 0, 1'b0, tr);
`ifndef ILLEGAL_TRAP_EN
    run_insn("illegal_nop", 32'h0000007F, 0, 0, 1'b0, tr);
    check("illegal_nop flag", 32'(bus.illegal_insn), 0);
`endif

    // Reset while a load sits in MEM
    bus.instruction = 32'h0000A103;
    bus.mem_ready = 1'b1;
    n = 0;
    while (bus.state != 3'd3 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_mem reached MEM", 32'(bus.state), 3);
    rst = 1'b1;
    #1;
    check("rst_mem mem_req", 32'(bus.mem_req), 0);
    check("rst_mem state", 32'(bus.state), 0);
    check("rst_mem retire_count", 32'(bus.retire_count), 0);
    check("rst_mem retired", 32'(bus.instr_retired), 0);
    @(posedge clk); #1;
    check("rst_mem reg_write", 32'(bus.reg_write), 0);
    check("rst_mem retired2", 32'(bus.instr_retired), 0);
    rst = 1'b0;
    #1;
    check("rst_mem fetch", 32'(bus.state), 0);
    check("rst_mem count", 32'(bus.retire_count), 0);
    exp_count = 0;

`ifdef ILLEGAL_TRAP_EN
    n_ops = 6;
`else
    n_ops = 7;
`endif
    for (int i = 0; i < 40; i++) begin
      rnd = $urandom();
      op = ops[$urandom_range(0, n_ops - 1)];
      run_insn("rand", {rnd[31:7], op}, $urandom_range(0, 2), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), tr);
    end

`ifdef ILLEGAL_TRAP_EN
    bus.instruction = 32'h0000007F;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("trap state", 32'(bus.state), 5);
      check("trap illegal", 32'(bus.illegal_insn), 1);
      check("trap mem_req", 32'(bus.mem_req), 0);
      check("trap retired", 32'(bus.instr_retired), 0);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("trap cleared", 32'(bus.illegal_insn), 0);
    check("trap fetch", 32'(bus.state), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
